// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM encoding and multi-cycle-op latency bounds.
package hazard_ctrl_pkg;

    localparam int MDU_LAT_MIN = 1;
    localparam int MDU_LAT_MAX = 16;
    localparam int MDU_LAT_DEF = 4;
    localparam int CNT_W       = $clog2(MDU_LAT_MAX);
    localparam int STAT_W      = 16;

    typedef enum logic {
        S_RUN = 1'b0,
        S_MDU = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, multi-cycle op stall
// and memory wait, with a saturating count of PC-stall cycles.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rt,
    input  logic              branch_taken,
    input  logic              mdu_start,
    input  logic              mem_busy,
    input  logic              stat_clr,
    output logic              pc_write,
    output logic              IF_ID_write,
    output logic              flush,
    output logic              ID_EX_write,
    output logic              ID_EX_bubble,
    output logic              EX_MEM_write,
    output logic              EX_MEM_bubble,
    output logic [STAT_W-1:0] stall_cnt
);

    // Entry cycle is itself a stall, so the counter covers the remaining MDU_LAT-2 stalls.
    localparam bit             MDU_STALLS = (MDU_LAT > 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = MDU_STALLS ? CNT_W'(MDU_LAT - 2) : '0;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [STAT_W-1:0] stall_cnt_reg, stall_cnt_next;

    logic mdu_stall;
    logic load_use;

    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_RUN;
            cnt_reg       <= '0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mdu_stall  = 1'b0;
        case (state_reg)
            S_RUN: begin
                if (mdu_start && MDU_STALLS) begin
                    mdu_stall  = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = S_MDU;
                end
            end
            S_MDU: begin
                if (cnt_reg != '0) begin
                    // Countdown continues under mem_busy; only the exit waits for memory.
                    mdu_stall = 1'b1;
                    cnt_next  = cnt_reg - 1'b1;
                end else if (!mem_busy) begin
                    state_next = S_RUN;
                end
            end
            default: begin
                state_next = S_RUN;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        pc_write      = 1'b1;
        IF_ID_write   = 1'b1;
        flush         = 1'b0;
        ID_EX_write   = 1'b1;
        ID_EX_bubble  = 1'b0;
        EX_MEM_write  = 1'b1;
        EX_MEM_bubble = 1'b0;
        if (!rst || mem_busy) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_write = 1'b0;
        end else if (mdu_stall) begin
            pc_write      = 1'b0;
            IF_ID_write   = 1'b0;
            ID_EX_write   = 1'b0;
            EX_MEM_bubble = 1'b1;
        end else if (load_use) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
        end else if (branch_taken) begin
            flush = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (stat_clr) begin
            stall_cnt_next = '0;
        end else if (!pc_write && (stall_cnt_reg != {STAT_W{1'b1}})) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hand-computed control vectors per cycle.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    // Vector order: {pc_write, IF_ID_write, flush, ID_EX_write, ID_EX_bubble, EX_MEM_write, EX_MEM_bubble}
    localparam logic [6:0] V_DEF  = 7'b1101010;
    localparam logic [6:0] V_LU   = 7'b0001110;
    localparam logic [6:0] V_BR   = 7'b1111010;
    localparam logic [6:0] V_MDU  = 7'b0000011;
    localparam logic [6:0] V_ZERO = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
    logic        id_uses_rt = 1'b0, ex_mem_read = 1'b0, branch_taken = 1'b0;
    logic        mdu_start = 1'b0, mem_busy = 1'b0, stat_clr = 1'b0;

    logic        pc_write, IF_ID_write, flush, ID_EX_write, ID_EX_bubble, EX_MEM_write, EX_MEM_bubble;
    logic [15:0] stall_cnt;
    logic        pc_write1, IF_ID_write1, flush1, ID_EX_write1, ID_EX_bubble1, EX_MEM_write1, EX_MEM_bubble1;
    logic [15:0] stall_cnt1;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_stall = '0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MDU_LAT(4)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .mdu_start(mdu_start), .mem_busy(mem_busy), .stat_clr(stat_clr),
        .pc_write(pc_write), .IF_ID_write(IF_ID_write), .flush(flush),
        .ID_EX_write(ID_EX_write), .ID_EX_bubble(ID_EX_bubble),
        .EX_MEM_write(EX_MEM_write), .EX_MEM_bubble(EX_MEM_bubble), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.MDU_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .mdu_start(mdu_start), .mem_busy(mem_busy), .stat_clr(stat_clr),
        .pc_write(pc_write1), .IF_ID_write(IF_ID_write1), .flush(flush1),
        .ID_EX_write(ID_EX_write1), .ID_EX_bubble(ID_EX_bubble1),
        .EX_MEM_write(EX_MEM_write1), .EX_MEM_bubble(EX_MEM_bubble1), .stall_cnt(stall_cnt1)
    );

    wire [6:0] outs  = {pc_write, IF_ID_write, flush, ID_EX_write, ID_EX_bubble, EX_MEM_write, EX_MEM_bubble};
    wire [6:0] outs1 = {pc_write1, IF_ID_write1, flush1, ID_EX_write1, ID_EX_bubble1, EX_MEM_write1, EX_MEM_bubble1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Check the current cycle's outputs, then clock once and let outputs settle.
    task automatic step(input string tag, input logic [6:0] exp_vec);
        #1;
        check({tag, "_outs"}, 32'(outs), 32'(exp_vec));
        check({tag, "_cnt"}, 32'(stall_cnt), 32'(exp_stall));
        $display("step %-12s outs=%b stall_cnt=%0d", tag, outs, stall_cnt);
        if (!exp_vec[6] && exp_stall != 16'hFFFF) exp_stall++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        id_rs = '0; id_rt = '0; ex_rt = '0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        branch_taken = 1'b0; mdu_start = 1'b0; mem_busy = 1'b0; stat_clr = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_outs", 32'(outs), 32'(V_ZERO));
        check("rst_cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        step("idle", V_DEF);

        // Load-use via rs, then released next cycle
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        step("lu_rs", V_LU);
        ex_mem_read = 1'b0;
        step("lu_done", V_DEF);
        // Load-use via rt only counts when rt is read
        ex_mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd1; id_rt = 5'd7; id_uses_rt = 1'b1;
        step("lu_rt", V_LU);
        id_uses_rt = 1'b0;
        step("lu_rt_unused", V_DEF);
        ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        step("lu_r0", V_DEF);

        // Branch alone, then branch under load-use
        clear_inputs();
        branch_taken = 1'b1;
        step("br", V_BR);
        ex_mem_read = 1'b1; ex_rt = 5'd3; id_rs = 5'd3;
        step("br_lu", V_LU);
        clear_inputs();
        mem_busy = 1'b1;
        step("busy_run", V_ZERO);
        mem_busy = 1'b0;

        // MDU_LAT=4 with mdu_start held 4 cycles; load-use and branch masked during stall
        mdu_start = 1'b1;
        #1; check("lat1_nostall", 32'(outs1), 32'(V_DEF));
        step("mdu0", V_MDU);
        ex_mem_read = 1'b1; ex_rt = 5'd3; id_rs = 5'd3; branch_taken = 1'b1;
        step("mdu1", V_MDU);
        clear_inputs(); mdu_start = 1'b1;
        step("mdu2", V_MDU);
        check("mdu_state_last", 32'(dut.state_reg), 32'(S_MDU));
        step("mdu_result", V_DEF);
        check("mdu_state_exit", 32'(dut.state_reg), 32'(S_RUN));
        mdu_start = 1'b0;
        step("mdu_after", V_DEF);

        // mem_busy during the result cycle holds S_MDU
        mdu_start = 1'b1;
        step("mb_mdu0", V_MDU);
        mdu_start = 1'b0;
        step("mb_mdu1", V_MDU);
        step("mb_mdu2", V_MDU);
        mem_busy = 1'b1;
        step("mb_busy0", V_ZERO);
        check("mb_state0", 32'(dut.state_reg), 32'(S_MDU));
        step("mb_busy1", V_ZERO);
        check("mb_state1", 32'(dut.state_reg), 32'(S_MDU));
        mem_busy = 1'b0;
        step("mb_result", V_DEF);
        check("mb_state_exit", 32'(dut.state_reg), 32'(S_RUN));

        // Reset while in S_MDU with cnt=1
        mdu_start = 1'b1;
        step("rs_mdu0", V_MDU);
        mdu_start = 1'b0;
        step("rs_mdu1", V_MDU);
        check("rs_cnt1", 32'(dut.cnt_reg), 32'd1);
        rst = 1'b0;
        #1;
        check("rs_outs", 32'(outs), 32'(V_ZERO));
        check("rs_state", 32'(dut.state_reg), 32'(S_RUN));
        exp_stall = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        step("rs_release", V_DEF);

        // Saturation and clear of stall_cnt
        ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
        repeat (70000) @(posedge clk);
        #1;
        check("sat_cnt", 32'(stall_cnt), 32'hFFFF);
        stat_clr = 1'b1;
        @(posedge clk); #1;
        check("clr_cnt", 32'(stall_cnt), 32'd0);
        stat_clr = 1'b0;
        @(posedge clk); #1;
        check("post_clr_cnt", 32'(stall_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
